button_conditioner: RTL and testbench

//  Front-end conditioner for the alarm-clock manual buttons; sits directly upstream of the clock top level.

---
 rtl/button_conditioner.sv | 148 ++++++++++++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Alarm-clock button front end: per-channel 2-FF sync, debounce, and press FSM
// producing a held level plus one-cycle advance pulses with optional auto-repeat.
module button_conditioner #(
    parameter int              NBTN          = 6,
    parameter int              DEB_CYCLES    = 4,
    parameter logic [NBTN-1:0] REPEAT_MASK   = 6'b001100,
    parameter int              REPEAT_DELAY  = 8,
    parameter int              REPEAT_PERIOD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] adv,
    output logic            any_adv
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int CNT_MAX = max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } state_t;

    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        logic [CW-1:0] r_dcnt;
        logic          r_level;
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_hcnt;
        logic [CW-1:0] w_hcnt_nxt;
        logic          r_adv;
        logic          w_adv_nxt;
        logic          w_flip;
        logic          w_rise;
        logic          w_fall;

        // The FSM reacts on the same edge the debounced level changes, so the
        // press pulse lines up with the first cycle of the new level.
        assign w_flip = (r_sync2[i] != r_level) && (r_dcnt == DEB_LAST);
        assign w_rise = w_flip && r_sync2[i];
        assign w_fall = w_flip && !r_sync2[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dcnt  <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[i] == r_level) begin
                r_dcnt  <= '0;
            end else if (r_dcnt == DEB_LAST) begin
                r_dcnt  <= '0;
                r_level <= r_sync2[i];
            end else begin
                r_dcnt  <= r_dcnt + CNT_ONE;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_IDLE;
                r_hcnt  <= '0;
                r_adv   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_adv   <= w_adv_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            w_adv_nxt   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HELD;
                        w_hcnt_nxt  = '0;
                        w_adv_nxt   = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (REPEAT_MASK[i]) begin
                        if (r_hcnt == RD_LAST) begin
                            w_state_nxt = ST_REPEAT;
                            w_hcnt_nxt  = '0;
                            w_adv_nxt   = 1'b1;
                        end else begin
                            w_hcnt_nxt  = r_hcnt + CNT_ONE;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == RP_LAST) begin
                        w_hcnt_nxt  = '0;
                        w_adv_nxt   = 1'b1;
                    end else begin
                        w_hcnt_nxt  = r_hcnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        assign level[i] = r_level;
        assign adv[i]   = r_adv;
    end

    assign any_adv = |adv;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters: reset, debounce,
// press pulse, auto-repeat, release, concurrency and reset mid-hold.
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [5:0] btn_raw;
    logic [5:0] level;
    logic [5:0] adv;
    logic       any_adv;

    int checks;
    int errors;

    button_conditioner dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .level   (level),
        .adv     (adv),
        .any_adv (any_adv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to one edge, then step just past it so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        btn_raw = 6'h3F;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (level !== 6'h00) begin
                errors++;
                $display("FAIL reset_level k=%0d got %h exp 00", k, level);
            end
            checks++;
            if (adv !== 6'h00) begin
                errors++;
                $display("FAIL reset_adv k=%0d got %h exp 00", k, adv);
            end
            checks++;
            if (any_adv !== 1'b0) begin
                errors++;
                $display("FAIL reset_any_adv k=%0d got %b exp 0", k, any_adv);
            end
        end
        btn_raw = 6'h00;
        tick();
        rst = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        btn_raw = 6'h01;
        for (int k = 1; k <= 56; k++) begin
            tick();
            checks++;
            if (level[0] !== (k >= 6)) begin
                errors++;
                $display("FAIL press_level k=%0d got %b exp %b", k, level[0], (k >= 6));
            end
            checks++;
            if (adv[0] !== (k == 6)) begin
                errors++;
                $display("FAIL press_adv k=%0d got %b exp %b", k, adv[0], (k == 6));
            end
            checks++;
            if (any_adv !== (k == 6)) begin
                errors++;
                $display("FAIL press_any_adv k=%0d got %b exp %b", k, any_adv, (k == 6));
            end
        end
        btn_raw = 6'h00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (level[0] !== (k < 6)) begin
                errors++;
                $display("FAIL release_level k=%0d got %b exp %b", k, level[0], (k < 6));
            end
            checks++;
            if (adv !== 6'h00) begin
                errors++;
                $display("FAIL release_adv k=%0d got %h exp 00", k, adv);
            end
        end
    endtask

    task automatic test_bounce();
        logic [14:0] pat;
        pat = 15'b000000000110111;
        for (int j = 0; j < 15; j++) begin
            btn_raw = {3'b000, pat[j], 2'b00};
            tick();
            checks++;
            if (level[2] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level j=%0d got %b exp 0", j, level[2]);
            end
            checks++;
            if (adv[2] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_adv j=%0d got %b exp 0", j, adv[2]);
            end
        end
        btn_raw = 6'h00;
        repeat (4) tick();
    endtask

    task automatic test_auto_repeat();
        logic exp_adv;
        btn_raw = 6'h04;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (adv[2] !== (k == 6)) begin
                errors++;
                $display("FAIL repeat_first k=%0d got %b exp %b", k, adv[2], (k == 6));
            end
        end
        for (int off = 1; off <= 29; off++) begin
            tick();
            exp_adv = (off == 8) || (off > 8 && ((off - 8) % 2) == 0);
            checks++;
            if (adv[2] !== exp_adv) begin
                errors++;
                $display("FAIL repeat_adv off=%0d got %b exp %b", off, adv[2], exp_adv);
            end
            checks++;
            if (level[2] !== 1'b1) begin
                errors++;
                $display("FAIL repeat_level off=%0d got %b exp 1", off, level[2]);
            end
        end
        btn_raw = 6'h00;
        repeat (12) tick();
        checks++;
        if (level !== 6'h00 || adv !== 6'h00) begin
            errors++;
            $display("FAIL repeat_drain got level=%h adv=%h exp 00/00", level, adv);
        end
    endtask

    task automatic test_release_repeat();
        logic exp_adv;
        logic exp_lvl;
        btn_raw = 6'h08;
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_adv = (k == 6) || (k >= 14 && k <= 22 && (k % 2) == 0);
            exp_lvl = (k >= 6 && k <= 22);
            checks++;
            if (adv[3] !== exp_adv) begin
                errors++;
                $display("FAIL relrep_adv k=%0d got %b exp %b", k, adv[3], exp_adv);
            end
            checks++;
            if (level[3] !== exp_lvl) begin
                errors++;
                $display("FAIL relrep_level k=%0d got %b exp %b", k, level[3], exp_lvl);
            end
            if (k == 17) btn_raw = 6'h00;
        end
    endtask

    task automatic test_concurrency();
        logic e2;
        logic e4;
        btn_raw = 6'h14;
        for (int k = 1; k <= 20; k++) begin
            tick();
            e2 = (k == 6) || (k >= 14 && (k % 2) == 0);
            e4 = (k == 6);
            checks++;
            if (adv[2] !== e2 || adv[4] !== e4) begin
                errors++;
                $display("FAIL conc_adv k=%0d got adv=%h exp ch2=%b ch4=%b", k, adv, e2, e4);
            end
            checks++;
            if (any_adv !== (e2 | e4)) begin
                errors++;
                $display("FAIL conc_any_adv k=%0d got %b exp %b", k, any_adv, (e2 | e4));
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (level !== 6'h00 || adv !== 6'h00 || any_adv !== 1'b0) begin
            errors++;
            $display("FAIL midhold_reset got level=%h adv=%h any=%b exp 00/00/0", level, adv, any_adv);
        end
        repeat (2) tick();
        checks++;
        if (level !== 6'h00 || adv !== 6'h00 || any_adv !== 1'b0) begin
            errors++;
            $display("FAIL midhold_reset_held got level=%h adv=%h any=%b exp 00/00/0", level, adv, any_adv);
        end
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            e2 = (k == 6) || (k == 14) || (k == 16);
            e4 = (k == 6);
            checks++;
            if (adv[2] !== e2 || adv[4] !== e4) begin
                errors++;
                $display("FAIL redetect_adv k=%0d got adv=%h exp ch2=%b ch4=%b", k, adv, e2, e4);
            end
            checks++;
            if (level[4] !== (k >= 6)) begin
                errors++;
                $display("FAIL redetect_level k=%0d got %b exp %b", k, level[4], (k >= 6));
            end
        end
        btn_raw = 6'h00;
        repeat (12) tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        btn_raw = 6'h00;
        #2;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_repeat();
        test_concurrency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
